// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the MM:SS stopwatch: 7-segment glyphs (active low,
// bit order g,f,e,d,c,b,a), BCD digit limits, anode selection and a 00..59 pair increment.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  localparam logic [3:0] AN_SEL_0 = 4'b1110;
  localparam logic [3:0] AN_SEL_1 = 4'b1101;
  localparam logic [3:0] AN_SEL_2 = 4'b1011;
  localparam logic [3:0] AN_SEL_3 = 4'b0111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] pattern;
    case (idx)
      2'd0:    pattern = AN_SEL_0;
      2'd1:    pattern = AN_SEL_1;
      2'd2:    pattern = AN_SEL_2;
      default: pattern = AN_SEL_3;
    endcase
    return pattern;
  endfunction

  // Increment a BCD pair in 00..59; returns {carry_out, tens, ones}.
  function automatic logic [8:0] pair_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t_n;
    logic [3:0] o_n;
    logic       carry;
    t_n   = tens;
    o_n   = ones + 4'd1;
    carry = 1'b0;
    if (ones == BCD_MAX_ONES) begin
      o_n = 4'd0;
      if (tens == BCD_MAX_TENS) begin
        t_n   = 4'd0;
        carry = 1'b1;
      end else begin
        t_n = tens + 4'd1;
      end
    end
    return {carry, t_n, o_n};
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Free-running dividers producing single-cycle tick enables (run, adjust, display scan)
// and a blink phase that flips on every blink-divider wrap.
module clock_divider #(
  parameter int unsigned DIV_1HZ   = 100_000_000,
  parameter int unsigned DIV_2HZ   = 50_000_000,
  parameter int unsigned DIV_FAST  = 100_000,
  parameter int unsigned DIV_BLINK = 33_333_333
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_1hz_o,
  output logic tick_2hz_o,
  output logic tick_fast_o,
  output logic blink_o
);

  localparam int unsigned W1 = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
  localparam int unsigned W2 = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
  localparam int unsigned WF = (DIV_FAST  > 1) ? $clog2(DIV_FAST)  : 1;
  localparam int unsigned WB = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;

  logic [W1-1:0] cnt_1hz_q;
  logic [W2-1:0] cnt_2hz_q;
  logic [WF-1:0] cnt_fast_q;
  logic [WB-1:0] cnt_blink_q;
  logic          blink_q;
  logic          tick_blink;

  assign tick_1hz_o  = (cnt_1hz_q   == W1'(DIV_1HZ - 1));
  assign tick_2hz_o  = (cnt_2hz_q   == W2'(DIV_2HZ - 1));
  assign tick_fast_o = (cnt_fast_q  == WF'(DIV_FAST - 1));
  assign tick_blink  = (cnt_blink_q == WB'(DIV_BLINK - 1));
  assign blink_o     = blink_q;

  // Each counter wraps to zero in the cycle its tick is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_1hz_q   <= '0;
      cnt_2hz_q   <= '0;
      cnt_fast_q  <= '0;
      cnt_blink_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      cnt_1hz_q   <= tick_1hz_o  ? '0 : cnt_1hz_q   + 1'b1;
      cnt_2hz_q   <= tick_2hz_o  ? '0 : cnt_2hz_q   + 1'b1;
      cnt_fast_q  <= tick_fast_o ? '0 : cnt_fast_q  + 1'b1;
      cnt_blink_q <= tick_blink  ? '0 : cnt_blink_q + 1'b1;
      blink_q     <= blink_q ^ tick_blink;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Level debouncer: the output adopts a new level only after STABLE_COUNT consecutive
// samples disagree with the current output.
module debouncer #(
  parameter int unsigned STABLE_COUNT = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o
);

  localparam int unsigned CntW = $clog2(STABLE_COUNT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (in_i != out_q) begin
      if (cnt_q == CntW'(STABLE_COUNT - 1)) begin
        out_d = in_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/stopwatch_top.sv
// MM:SS stopwatch top: debounced controls, tick dividers, BCD time counter with pause and
// manual adjust, and a 4-digit multiplexed 7-segment driver.
// Optional: define STOPWATCH_BLINK_EN to blank the selected pair during adjust while the
// blink phase is low.
module stopwatch_top #(
  parameter int unsigned DIV_1HZ      = 100_000_000,
  parameter int unsigned DIV_2HZ      = 50_000_000,
  parameter int unsigned DIV_FAST     = 100_000,
  parameter int unsigned DIV_BLINK    = 33_333_333,
  parameter int unsigned STABLE_COUNT = 1_000_000
) (
  input  logic       clk_100mhz,
  input  logic       btn_reset_raw,
  input  logic       btn_pause_raw,
  input  logic       sw_adj_raw,
  input  logic       sw_sel_raw,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  import stopwatch_pkg::*;

`ifdef STOPWATCH_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic       db_rst, db_pause, adj, sel;
  logic       tick_1hz, tick_2hz, tick_fast, blink_phase;
  logic [3:0] mt, mo, st, so;
  logic [3:0] mt_q, mo_q, st_q, so_q, mt_d, mo_d, st_d, so_d;
  logic [8:0] sec_inc, min_inc;
  logic       paused_q, paused_d, pause_prev_q;
  logic [1:0] scan_q;
  logic [3:0] digit;
  logic       blank;

  debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_rst (
    .clk_i(clk_100mhz), .rst_i(btn_reset_raw), .in_i(btn_reset_raw), .out_o(db_rst)
  );
  debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_pause (
    .clk_i(clk_100mhz), .rst_i(btn_reset_raw), .in_i(btn_pause_raw), .out_o(db_pause)
  );
  debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_adj (
    .clk_i(clk_100mhz), .rst_i(btn_reset_raw), .in_i(sw_adj_raw), .out_o(adj)
  );
  debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_sel (
    .clk_i(clk_100mhz), .rst_i(btn_reset_raw), .in_i(sw_sel_raw), .out_o(sel)
  );

  clock_divider #(
    .DIV_1HZ(DIV_1HZ), .DIV_2HZ(DIV_2HZ), .DIV_FAST(DIV_FAST), .DIV_BLINK(DIV_BLINK)
  ) u_div (
    .clk_i(clk_100mhz), .rst_i(btn_reset_raw), .tick_1hz_o(tick_1hz), .tick_2hz_o(tick_2hz),
    .tick_fast_o(tick_fast), .blink_o(blink_phase)
  );

  assign sec_inc = pair_inc(st_q, so_q);
  assign min_inc = pair_inc(mt_q, mo_q);
  assign paused_d = paused_q ^ (db_pause & ~pause_prev_q);

  // Next time value: debounced reset, then adjust (2 Hz, no carry), then run (1 Hz).
  always_comb begin
    {mt_d, mo_d, st_d, so_d} = {mt_q, mo_q, st_q, so_q};
    if (db_rst) begin
      {mt_d, mo_d, st_d, so_d} = '0;
    end else if (adj) begin
      if (tick_2hz) begin
        if (sel) begin
          {st_d, so_d} = sec_inc[7:0];
        end else begin
          {mt_d, mo_d} = min_inc[7:0];
        end
      end
    end else if (!paused_q && tick_1hz) begin
      {st_d, so_d} = sec_inc[7:0];
      if (sec_inc[8]) begin
        {mt_d, mo_d} = min_inc[7:0];
      end
    end
  end

  // Time digits, pause state and scan index.
  always_ff @(posedge clk_100mhz or posedge btn_reset_raw) begin
    if (btn_reset_raw) begin
      {mt_q, mo_q, st_q, so_q} <= '0;
      paused_q                 <= 1'b0;
      pause_prev_q             <= 1'b0;
      scan_q                   <= 2'd0;
    end else begin
      {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
      paused_q                 <= paused_d;
      pause_prev_q             <= db_pause;
      scan_q                   <= tick_fast ? scan_q + 2'd1 : scan_q;
    end
  end

  assign mt = mt_q;
  assign mo = mo_q;
  assign st = st_q;
  assign so = so_q;

  // Display mux; scan index 0/1 is the seconds pair, 2/3 the minutes pair.
  always_comb begin
    case (scan_q)
      2'd0:    digit = so;
      2'd1:    digit = st;
      2'd2:    digit = mo;
      default: digit = mt;
    endcase
    blank = BlinkEn && adj && !blink_phase && (sel ? !scan_q[1] : scan_q[1]);
    seg   = blank ? SEG_BLANK : seg_decode(digit);
    an    = an_select(scan_q);
    dp    = 1'b1;
  end

endmodule

// File: tb/tb_stopwatch_top.sv
// Randomised bench for stopwatch_top with a time-in-seconds reference model and a
// queue-based scoreboard checked once per clock on the falling edge.
module tb_stopwatch_top;

  localparam int D1 = 10;
  localparam int D2 = 5;
  localparam int DF = 2;
  localparam int DB = 7;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_raw = 1'b0;
  logic       adj_raw = 1'b0;
  logic       sel_raw = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  stopwatch_top #(
    .DIV_1HZ(D1), .DIV_2HZ(D2), .DIV_FAST(DF), .DIV_BLINK(DB), .STABLE_COUNT(SC)
  ) dut (
    .clk_100mhz(clk), .btn_reset_raw(rst), .btn_pause_raw(pause_raw),
    .sw_adj_raw(adj_raw), .sw_sel_raw(sel_raw), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [15:0] digits;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: time kept as whole seconds 0..3599.
  int   n = 0;
  int   t = 0;
  int   idx = 0;
  bit   paused = 0;
  bit   prev_pause = 0;
  bit   blink = 0;
  bit   db[4];
  bit   hist[4][$];

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic exp_t expected();
    exp_t e;
    int   d[4];
    bit   blank;
    d[0] = (t % 60) % 10;
    d[1] = (t % 60) / 10;
    d[2] = (t / 60) % 10;
    d[3] = (t / 60) / 10;
    blank = 1'b0;
`ifdef STOPWATCH_BLINK_EN
    blank = db[2] && !blink && (db[3] ? (idx < 2) : (idx >= 2));
`endif
    e.an     = an_tab[idx];
    e.seg    = blank ? 7'h7f : glyph[d[idx]];
    e.digits = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
    return e;
  endfunction

  task automatic model_step();
    bit raw[4];
    bit all_diff;
    int mm, ss;
    raw[0] = rst; raw[1] = pause_raw; raw[2] = adj_raw; raw[3] = sel_raw;
    if (rst) begin
      n = 0; t = 0; idx = 0; paused = 0; prev_pause = 0; blink = 0;
      for (int i = 0; i < 4; i++) begin
        db[i] = 0;
        hist[i].delete();
      end
    end else begin
      n++;
      if (db[0]) begin
        t = 0;
      end else if (db[2]) begin
        if (n % D2 == 0) begin
          mm = t / 60;
          ss = t % 60;
          if (db[3]) ss = (ss + 1) % 60;
          else mm = (mm + 1) % 60;
          t = mm * 60 + ss;
        end
      end else if (!paused && (n % D1 == 0)) begin
        t = (t + 1) % 3600;
      end
      if (db[1] && !prev_pause) paused = !paused;
      prev_pause = db[1];
      if (n % DF == 0) idx = (idx + 1) % 4;
      if (n % DB == 0) blink = !blink;
      // A level is accepted once the last SC samples all disagree with it.
      for (int i = 0; i < 4; i++) begin
        hist[i].push_back(raw[i]);
        if (hist[i].size() > SC) void'(hist[i].pop_front());
        if (hist[i].size() == SC) begin
          all_diff = 1;
          for (int j = 0; j < SC; j++) if (hist[i][j] == db[i]) all_diff = 0;
          if (all_diff) db[i] = raw[i];
        end
      end
    end
    exp_q.push_back(expected());
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the display is presented every cycle, so one entry is retired per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", int'(an), int'(e.an));
        check("seg", int'(seg), int'(e.seg));
        check("dp", int'(dp), 1);
        check("digits", int'({dut.mt, dut.mo, dut.st, dut.so}), int'(e.digits));
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_raw = 1'b1;
    cyc(4);
    pause_raw = 1'b0;
    cyc(4);
  endtask

  function automatic int field(input bit secs);
    return secs ? (t % 60) : (t / 60);
  endfunction

  task automatic adjust_to(input bit want_sel, input int target);
    int guard;
    guard = 0;
    adj_raw = 1'b1;
    sel_raw = want_sel;
    while (field(want_sel) != target && guard < 1000) begin
      cyc(1);
      guard++;
    end
    tests_run++;
    if (guard >= 1000) begin
      tests_failed++;
      $display("FAIL adjust_bound: field %0d, expected %0d", field(want_sel), target);
    end
  endtask

  initial begin
    int pick;
    int hold;
    cyc(8);
    rst = 1'b0;
    cyc(40);
    // Pause, hold frozen, resume.
    pulse_pause();
    cyc(16 + int'($urandom_range(0, 10)));
    pulse_pause();
    cyc(30);
    // Adjust seconds, then minutes.
    adj_raw = 1'b1;
    sel_raw = 1'b1;
    cyc(80);
    sel_raw = 1'b0;
    cyc(80);
    // Seconds wrap 59 -> 00 in adjust.
    adjust_to(1'b1, 59);
    cyc(12);
    // Park at 59:55 then run through the 59:59 rollover.
    for (int a = 0; a < 4; a++) begin
      adjust_to(1'b0, 59);
      sel_raw = 1'b1;
      cyc(3);
      if (t / 60 == 59) break;
    end
    adjust_to(1'b1, 55);
    if (paused) pulse_pause();
    adj_raw = 1'b0;
    cyc(100);
    // Pause while adjusting, then leave adjust: stays frozen.
    adj_raw = 1'b1;
    pulse_pause();
    cyc(10);
    adj_raw = 1'b0;
    cyc(40);
    pulse_pause();
    cyc(30);
    // Reset mid-run.
    rst = 1'b1;
    cyc(12);
    rst = 1'b0;
    cyc(5);
    // Random input activity, including glitches shorter than the debounce window.
    for (int k = 0; k < 300; k++) begin
      pick = int'($urandom_range(0, 39));
      hold = int'($urandom_range(1, 8));
      if (pick == 0) begin
        rst = 1'b1;
        cyc(hold);
        rst = 1'b0;
      end else if (pick < 14) begin
        pause_raw = 1'($urandom_range(0, 1));
      end else if (pick < 27) begin
        adj_raw = 1'($urandom_range(0, 1));
      end else begin
        sel_raw = 1'($urandom_range(0, 1));
      end
      cyc(hold);
    end
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
